// File: rtl/text_console.sv
// rtl/text_console.sv - character-stream console writing glyph cells into tram with cursor, wrap and hardware scroll
// Optional feature macro: CONSOLE_TAB_EN (0x09 advances to the next tab stop instead of printing)
module text_console #(
  parameter int WORD     = 32,
  parameter int BYTE_CNT = 4,
  parameter int ADDRW    = 11,
  parameter int CIDXW    = 4,
  parameter int HRES     = 84,
  parameter int VRES     = 24,
  parameter int TAB_W    = 8
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  input  logic                char_valid,
  output logic                char_ready,
  input  logic [7:0]          char_data,
  input  logic [CIDXW-1:0]    colr_fg,
  input  logic [CIDXW-1:0]    colr_bg,
  input  logic                cmd_clear,
  output logic                busy,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [7:0]          cursor_x,
  output logic [7:0]          cursor_y
);

  localparam int AW1 = ADDRW + 1;
  localparam int AW2 = ADDRW + 2;
  localparam int CELLS = HRES * VRES;
  localparam logic [AW2-1:0]   CELLS_W2  = AW2'(CELLS);
  localparam logic [AW1-1:0]   CELLS_W1  = AW1'(CELLS);
  localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(CELLS - 1);
  localparam logic [ADDRW-1:0] LAST_LCNT = ADDRW'(HRES - 1);
  localparam logic [ADDRW-1:0] HRES_A    = ADDRW'(HRES);
  localparam logic [7:0]       LAST_COL  = 8'(HRES - 1);
  localparam logic [7:0]       LAST_ROW  = 8'(VRES - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCRN} state_t;

  state_t             state;
  logic [ADDRW-1:0]   line_base;
  logic [ADDRW-1:0]   clr_addr;
  logic [ADDRW-1:0]   clr_cnt;
  logic [CIDXW-1:0]   fg_q;
  logic [CIDXW-1:0]   bg_q;
  logic               accept;
  logic [AW2-1:0]     addr_sum;
  logic [ADDRW-1:0]   addr_cur;
  logic [AW1-1:0]     scroll_sum;
  logic [ADDRW-1:0]   scroll_nxt;
  logic [ADDRW-1:0]   clr_addr_nxt;
  logic [7:0]         x_nxt;
  logic               adv_row;
  logic               do_write;

  function automatic logic [WORD-1:0] make_word(input logic [7:0] glyph,
                                                input logic [CIDXW-1:0] fg,
                                                input logic [CIDXW-1:0] bg);
    logic [WORD-1:0] w;
    w = '0;
    w[7:0] = glyph;
    w[8 +: CIDXW] = fg;
    w[8 + CIDXW +: CIDXW] = bg;
    return w;
  endfunction

  assign char_ready = rst_sys_n && (state == IDLE) && !cmd_clear;
  assign accept     = char_valid && char_ready;
  assign busy       = (state != IDLE);

  // Sum of three in-range terms is below 3*CELLS, so two conditional subtracts give the modulo.
  assign addr_sum = AW2'(scroll_offs) + AW2'(line_base) + AW2'(cursor_x);
  always_comb begin
    if (addr_sum >= CELLS_W2 + CELLS_W2)
      addr_cur = ADDRW'(addr_sum - CELLS_W2 - CELLS_W2);
    else if (addr_sum >= CELLS_W2)
      addr_cur = ADDRW'(addr_sum - CELLS_W2);
    else
      addr_cur = ADDRW'(addr_sum);
  end

  assign scroll_sum   = AW1'(scroll_offs) + AW1'(HRES_A);
  assign scroll_nxt   = (scroll_sum >= CELLS_W1) ? ADDRW'(scroll_sum - CELLS_W1) : ADDRW'(scroll_sum);
  assign clr_addr_nxt = (clr_addr == LAST_CELL) ? '0 : clr_addr + 1'b1;

`ifdef CONSOLE_TAB_EN
  logic [7:0] tab_stop;
  assign tab_stop = (cursor_x | 8'(TAB_W - 1)) + 8'd1;
`endif

  always_comb begin
    x_nxt    = cursor_x;
    adv_row  = 1'b0;
    do_write = 1'b0;
    if (char_data == 8'h0D) begin
      x_nxt = 8'd0;
    end else if (char_data == 8'h0A) begin
      x_nxt   = 8'd0;
      adv_row = 1'b1;
    end else if (char_data == 8'h08) begin
      if (cursor_x != 8'd0) x_nxt = cursor_x - 8'd1;
`ifdef CONSOLE_TAB_EN
    end else if (char_data == 8'h09) begin
      if (tab_stop >= 8'(HRES)) begin
        x_nxt   = 8'd0;
        adv_row = 1'b1;
      end else begin
        x_nxt = tab_stop;
      end
`endif
    end else begin
      do_write = 1'b1;
      if (cursor_x == LAST_COL) begin
        x_nxt   = 8'd0;
        adv_row = 1'b1;
      end else begin
        x_nxt = cursor_x + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state       <= IDLE;
      tram_we     <= '0;
      tram_addr   <= '0;
      tram_din    <= '0;
      scroll_offs <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      line_base   <= '0;
      clr_addr    <= '0;
      clr_cnt     <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
    end else begin
      tram_we <= '0;
      case (state)
        IDLE: begin
          if (cmd_clear) begin
            fg_q        <= colr_fg;
            bg_q        <= colr_bg;
            scroll_offs <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            line_base   <= '0;
            clr_addr    <= '0;
            clr_cnt     <= '0;
            state       <= CLR_SCRN;
          end else if (accept) begin
            fg_q     <= colr_fg;
            bg_q     <= colr_bg;
            cursor_x <= x_nxt;
            if (do_write) begin
              tram_we   <= '1;
              tram_addr <= addr_cur;
              tram_din  <= make_word(char_data, colr_fg, colr_bg);
            end
            if (adv_row) begin
              if (cursor_y != LAST_ROW) begin
                cursor_y  <= cursor_y + 8'd1;
                line_base <= line_base + HRES_A;
              end else begin
                // Old top row becomes the new bottom row once the window slides down.
                scroll_offs <= scroll_nxt;
                clr_addr    <= scroll_offs;
                clr_cnt     <= '0;
                state       <= CLR_LINE;
              end
            end
          end
        end
        CLR_LINE, CLR_SCRN: begin
          tram_we   <= '1;
          tram_addr <= clr_addr;
          tram_din  <= make_word(8'h20, fg_q, bg_q);
          clr_addr  <= clr_addr_nxt;
          clr_cnt   <= clr_cnt + 1'b1;
          if ((state == CLR_LINE && clr_cnt == LAST_LCNT) ||
              (state == CLR_SCRN && clr_cnt == LAST_CELL))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - directed self-checking bench for text_console
module tb_text_console;
  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_data = 8'h00;
  logic [3:0]  colr_fg = 4'h0;
  logic [3:0]  colr_bg = 4'h0;
  logic        cmd_clear = 1'b0;
  logic        busy;
  logic [3:0]  tram_we;
  logic [10:0] tram_addr;
  logic [31:0] tram_din;
  logic [10:0] scroll_offs;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;

  int errors = 0;
  int checks = 0;
  int bad;
  logic [10:0] wa_q[$];
  logic [31:0] wd_q[$];

  text_console dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .colr_fg(colr_fg), .colr_bg(colr_bg), .cmd_clear(cmd_clear),
    .busy(busy), .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
    .scroll_offs(scroll_offs), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (tram_we !== 4'h0) begin
      wa_q.push_back(tram_addr);
      wd_q.push_back(tram_din);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sync_neg();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic flush();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic apply_reset();
    char_valid = 1'b0;
    cmd_clear  = 1'b0;
    rst_sys_n  = 1'b0;
    tick();
    tick();
    rst_sys_n = 1'b1;
    tick();
    flush();
  endtask

  task automatic send_char(input logic [7:0] c);
    char_data  = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b still set after %0d cycles", busy, max_cycles);
    end
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    tick();
    tick();
    checks++; if (tram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h want 0", tram_we); end
    checks++; if (scroll_offs !== 11'd0) begin errors++; $display("FAIL reset_scroll: got %0d want 0", scroll_offs); end
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_sys_n = 1'b1;
    tick();
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", char_ready); end
    flush();
  endtask

  task automatic test_first_char();
    colr_fg = 4'h2;
    colr_bg = 4'h0;
    send_char(8'h41);
    checks++; if (tram_we !== 4'hF) begin errors++; $display("FAIL first_we: got %h want f", tram_we); end
    checks++; if (tram_addr !== 11'd0) begin errors++; $display("FAIL first_addr: got %0d want 0", tram_addr); end
    checks++; if (tram_din !== 32'h0000_0241) begin errors++; $display("FAIL first_din: got %h want 00000241", tram_din); end
    checks++; if (cursor_x !== 8'd1) begin errors++; $display("FAIL first_x: got %0d want 1", cursor_x); end
    tick();
    checks++; if (tram_we !== 4'h0) begin errors++; $display("FAIL first_idle_we: got %h want 0", tram_we); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    char_data  = 8'h78;
    char_valid = 1'b1;
    for (int i = 0; i < 84; i++) tick();
    char_valid = 1'b0;
    sync_neg();
    checks++; if (wa_q.size() != 84) begin errors++; $display("FAIL b2b_count: got %0d want 84", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== 11'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_addrs: %0d addresses out of order, want 0..83", bad); end
    checks++; if (wa_q.size() > 0 && wa_q[wa_q.size()-1] !== 11'd83) begin errors++; $display("FAIL b2b_last: got %0d want 83", wa_q[wa_q.size()-1]); end
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd1) begin errors++; $display("FAIL b2b_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y); end
    send_char(8'h79);
    checks++; if (tram_we !== 4'hF || tram_addr !== 11'd84) begin errors++; $display("FAIL b2b_next: got we=%h addr=%0d want we=f addr=84", tram_we, tram_addr); end
  endtask

  task automatic test_scroll();
    apply_reset();
    colr_fg = 4'h3;
    colr_bg = 4'h1;
    char_data  = 8'h0A;
    char_valid = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    char_valid = 1'b0;
    checks++; if (busy !== 1'b1 || char_ready !== 1'b0) begin errors++; $display("FAIL scroll_busy: got busy=%b ready=%b want 1/0", busy, char_ready); end
    checks++; if (scroll_offs !== 11'd84) begin errors++; $display("FAIL scroll_offs: got %0d want 84", scroll_offs); end
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd23) begin errors++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,23)", cursor_x, cursor_y); end
    wait_idle(200);
    sync_neg();
    checks++; if (wa_q.size() != 84) begin errors++; $display("FAIL scroll_count: got %0d want 84", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== 11'(i) || wd_q[i] !== 32'h0000_1320) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL scroll_clear: %0d bad words, want addr 0..83 din 00001320", bad); end
    flush();
    send_char(8'h7A);
    checks++; if (tram_we !== 4'hF || tram_addr !== 11'd0) begin errors++; $display("FAIL scroll_z: got we=%h addr=%0d want we=f addr=0", tram_we, tram_addr); end
  endtask

  task automatic test_clear();
    colr_fg    = 4'h5;
    colr_bg    = 4'h6;
    char_data  = 8'h51;
    char_valid = 1'b1;
    cmd_clear  = 1'b1;
    tick();
    char_valid = 1'b0;
    cmd_clear  = 1'b0;
    flush();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b want 1", busy); end
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd0 || scroll_offs !== 11'd0) begin errors++; $display("FAIL clear_home: got (%0d,%0d) scroll=%0d want (0,0) 0", cursor_x, cursor_y, scroll_offs); end
    wait_idle(2100);
    sync_neg();
    checks++; if (wa_q.size() != 2016) begin errors++; $display("FAIL clear_count: got %0d want 2016", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== 11'(i) || wd_q[i] !== 32'h0000_6520) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_words: %0d bad words, want addr 0..2015 din 00006520", bad); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", char_ready); end
  endtask

  task automatic test_bs_cr();
    apply_reset();
    send_char(8'h08);
    sync_neg();
    checks++; if (cursor_x !== 8'd0 || wa_q.size() != 0) begin errors++; $display("FAIL bs_home: got x=%0d writes=%0d want 0 0", cursor_x, wa_q.size()); end
    for (int i = 0; i < 5; i++) send_char(8'h61);
    send_char(8'h08);
    checks++; if (cursor_x !== 8'd4 || tram_we !== 4'h0) begin errors++; $display("FAIL bs_step: got x=%0d we=%h want 4 0", cursor_x, tram_we); end
    send_char(8'h61);
    sync_neg();
    flush();
    send_char(8'h0D);
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd0 || tram_we !== 4'h0) begin errors++; $display("FAIL cr: got (%0d,%0d) we=%h want (0,0) 0", cursor_x, cursor_y, tram_we); end
  endtask

  task automatic test_tab();
    apply_reset();
    for (int i = 0; i < 3; i++) send_char(8'h62);
    sync_neg();
    flush();
    send_char(8'h09);
    sync_neg();
`ifdef CONSOLE_TAB_EN
    checks++; if (cursor_x !== 8'd8 || wa_q.size() != 0) begin errors++; $display("FAIL tab_3: got x=%0d writes=%0d want 8 0", cursor_x, wa_q.size()); end
    for (int i = 0; i < 72; i++) send_char(8'h64);
    send_char(8'h09);
    checks++; if (cursor_x !== 8'd0 || cursor_y !== 8'd1 || tram_we !== 4'h0) begin errors++; $display("FAIL tab_80: got (%0d,%0d) we=%h want (0,1) 0", cursor_x, cursor_y, tram_we); end
`else
    checks++; if (wa_q.size() != 1 || cursor_x !== 8'd4) begin errors++; $display("FAIL tab_print: got writes=%0d x=%0d want 1 4", wa_q.size(), cursor_x); end
    checks++; if (wa_q.size() > 0 && (wa_q[0] !== 11'd3 || wd_q[0][7:0] !== 8'h09)) begin errors++; $display("FAIL tab_glyph: got addr=%0d glyph=%h want 3 09", wa_q[0], wd_q[0][7:0]); end
`endif
  endtask

  task automatic test_reset_mid_clear();
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_sys_n = 1'b0;
    tick();
    checks++; if (tram_we !== 4'h0 || scroll_offs !== 11'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: got we=%h scroll=%0d busy=%b want 0 0 0", tram_we, scroll_offs, busy); end
    flush();
    tick();
    rst_sys_n = 1'b1;
    tick();
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", char_ready); end
    for (int i = 0; i < 3; i++) tick();
    sync_neg();
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL rst_mid_writes: got %0d want 0", wa_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_char();
    test_back_to_back();
    test_scroll();
    test_clear();
    test_bs_cr();
    test_tab();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
